// File: rtl/tick_timer.sv
// Down-counting tick timer with one-shot / auto-reload modes, pause/resume,
// single-cycle expiry pulse and sticky irq / overrun flags.
module tick_timer #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  input  logic          periodic,
  input  logic [DW-1:0] load_val,
  input  logic          irq_clr,
  output logic [DW-1:0] cnt,
  output logic [1:0]    state,
  output logic          busy,
  output logic          expire,
  output logic          irq,
  output logic          ovr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        st_q, st_n;
  logic [DW-1:0] cnt_q, cnt_n;
  logic [DW-1:0] period_q, period_n;
  logic          mode_q, mode_n;
  logic          expire_q, expire_n;
  logic          irq_q, irq_n;
  logic          ovr_q, ovr_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      mode_q   <= 1'b0;
      expire_q <= 1'b0;
      irq_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      st_q     <= st_n;
      cnt_q    <= cnt_n;
      period_q <= period_n;
      mode_q   <= mode_n;
      expire_q <= expire_n;
      irq_q    <= irq_n;
      ovr_q    <= ovr_n;
    end
  end

  // Command decode, priority stop > start > pause > tick.
  always_comb begin
    st_n     = st_q;
    cnt_n    = cnt_q;
    period_n = period_q;
    mode_n   = mode_q;
    expire_n = 1'b0;

    if (stop) begin
      st_n  = IDLE;
      cnt_n = '0;
    end else if (start) begin
      if (st_q == PAUSE) begin
        st_n = RUN;
      end else if (load_val != '0) begin
        period_n = load_val;
        mode_n   = periodic;
        cnt_n    = load_val;
        st_n     = RUN;
      end
    end else if (pause) begin
      if (st_q == RUN) st_n = PAUSE;
    end else if (tick && (st_q == RUN)) begin
      if (cnt_q > DW'(1)) begin
        cnt_n = cnt_q - DW'(1);
      end else begin
        expire_n = 1'b1;
        if (mode_q) begin
          cnt_n = period_q;
        end else begin
          cnt_n = '0;
          st_n  = DONE;
        end
      end
    end

    // Set wins over clear for both sticky flags.
    irq_n = (irq_q & ~irq_clr) | expire_n;
    ovr_n = (ovr_q & ~irq_clr) | (expire_n & irq_q);
  end

  assign cnt    = cnt_q;
  assign state  = st_q;
  assign busy   = (st_q == RUN) || (st_q == PAUSE);
  assign expire = expire_q;
  assign irq    = irq_q;
  assign ovr    = ovr_q;

endmodule

// File: tb/tb_tick_timer.sv
// Scoreboard bench for tick_timer: a behavioural model pushes expected
// outputs per driven cycle, popped and compared after the clock edge.
module tb_tick_timer;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tick, start, stop, pause, periodic, irq_clr;
  logic [DW-1:0] load_val;
  logic [DW-1:0] cnt;
  logic [1:0]    state;
  logic          busy, expire, irq, ovr;

  typedef struct {
    logic [DW-1:0] cnt;
    logic [1:0]    st;
    logic          busy;
    logic          expire;
    logic          irq;
    logic          ovr;
  } exp_t;

  exp_t sb[$];

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned step_no = 0;

  // Reference model state
  logic [DW-1:0] m_cnt, m_period;
  logic [1:0]    m_st;
  logic          m_mode, m_irq, m_ovr, m_exp;

  tick_timer #(.DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .periodic (periodic),
    .load_val (load_val),
    .irq_clr  (irq_clr),
    .cnt      (cnt),
    .state    (state),
    .busy     (busy),
    .expire   (expire),
    .irq      (irq),
    .ovr      (ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = '0; m_period = '0; m_st = 2'd0;
    m_mode = 1'b0; m_irq = 1'b0; m_ovr = 1'b0; m_exp = 1'b0;
  endtask

  task automatic model_cycle(input logic t, s, p, ps, per, clr, input logic [DW-1:0] lv);
    logic new_irq, new_ovr;
    m_exp = 1'b0;
    if (p) begin
      m_st  = 2'd0;
      m_cnt = '0;
    end else if (s) begin
      if (m_st == 2'd2) m_st = 2'd1;
      else if (lv != '0) begin
        m_period = lv; m_mode = per; m_cnt = lv; m_st = 2'd1;
      end
    end else if (ps) begin
      if (m_st == 2'd1) m_st = 2'd2;
    end else if (t && m_st == 2'd1) begin
      if (m_cnt == 1) begin
        m_exp = 1'b1;
        if (m_mode) m_cnt = m_period;
        else begin m_cnt = '0; m_st = 2'd3; end
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
    new_ovr = (m_exp && m_irq) || (m_ovr && !clr);
    new_irq = m_exp || (m_irq && !clr);
    m_ovr = new_ovr;
    m_irq = new_irq;
  endtask

  // Drive one cycle of inputs, predict, then compare after the edge.
  task automatic step(input logic t, s, p, ps, per, clr, input logic [DW-1:0] lv);
    exp_t e;
    tick = t; start = s; stop = p; pause = ps; periodic = per; irq_clr = clr; load_val = lv;
    model_cycle(t, s, p, ps, per, clr, lv);
    e.cnt = m_cnt; e.st = m_st; e.busy = (m_st == 2'd1) || (m_st == 2'd2);
    e.expire = m_exp; e.irq = m_irq; e.ovr = m_ovr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    e = sb.pop_front();
    check($sformatf("cnt@%0d", step_no),    64'(cnt),    64'(e.cnt));
    check($sformatf("state@%0d", step_no),  64'(state),  64'(e.st));
    check($sformatf("busy@%0d", step_no),   64'(busy),   64'(e.busy));
    check($sformatf("expire@%0d", step_no), 64'(expire), 64'(e.expire));
    check($sformatf("irq@%0d", step_no),    64'(irq),    64'(e.irq));
    check($sformatf("ovr@%0d", step_no),    64'(ovr),    64'(e.ovr));
  endtask

  task automatic idle_cyc();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask
  task automatic do_tick();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask
  task automatic do_start(input logic per, input logic [DW-1:0] lv);
    step(1'b0, 1'b1, 1'b0, 1'b0, per, 1'b0, lv);
  endtask
  task automatic do_clr();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
  endtask
  task automatic do_stop();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cnt"},    64'(cnt),    64'd0);
    check({tag, "_state"},  64'(state),  64'd0);
    check({tag, "_busy"},   64'(busy),   64'd0);
    check({tag, "_expire"}, 64'(expire), 64'd0);
    check({tag, "_irq"},    64'(irq),    64'd0);
    check({tag, "_ovr"},    64'(ovr),    64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    tick = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    periodic = 1'b0; irq_clr = 1'b0; load_val = '0;
    model_reset();
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Zero load in IDLE is ignored
    do_start(1'b0, 32'd0);

    // One-shot, load 3
    do_start(1'b0, 32'd3);
    repeat (3) do_tick();
    idle_cyc();
    do_tick();
    do_clr();

    // Periodic with overrun, load 2, six ticks
    do_start(1'b1, 32'd2);
    repeat (6) do_tick();
    do_clr();
    do_stop();

    // Pause / resume, load 5; resume ignores load_val
    do_start(1'b0, 32'd5);
    repeat (2) do_tick();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    repeat (3) do_tick();
    do_start(1'b1, 32'd9);
    repeat (3) do_tick();
    do_clr();

    // tick+stop at cnt=1
    do_start(1'b0, 32'd2);
    do_tick();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    // tick+start at cnt=1 restarts with 7
    do_start(1'b0, 32'd2);
    do_tick();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd7);
    // restart to period 1 periodic: expire every tick; expire with irq_clr keeps irq
    do_start(1'b1, 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    repeat (3) do_tick();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    do_clr();
    // start with zero load in RUN is ignored, as is the same-cycle tick
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    do_stop();

    // Random mixed traffic
    for (int i = 0; i < 80; i++) begin
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 5) == 0),
           DW'($urandom_range(0, 4)));
    end

    // Asynchronous reset mid-run at cnt=4 with irq set
    do_stop();
    do_start(1'b1, 32'd1);
    do_tick();
    do_start(1'b0, 32'd6);
    repeat (2) do_tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_start(1'b0, 32'd3);
    do_tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tick_timer.md
TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 SHALL have parameter DW, default 32, width of the count and load value.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port tick, input, 1, single-cycle strobe from the upstream prescaler carry-out; one tick means one timer decrement.
REQ-005 SHALL have port start, input, 1, (re)start or resume request.
REQ-006 SHALL have port stop, input, 1, abort request.
REQ-007 SHALL have port pause, input, 1, freeze request.
REQ-008 SHALL have port periodic, input, 1, mode select sampled on start: 1 means auto-reload, 0 means one-shot.
REQ-009 SHALL have port load_val, input, DW, period in ticks, sampled on start.
REQ-010 SHALL have port irq_clr, input, 1, clears irq and ovr.
REQ-011 SHALL have port cnt, output, DW, remaining ticks.
REQ-012 SHALL have port state, output, 2, encoding IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-013 SHALL have port busy, output, 1, high in RUN or PAUSE.
REQ-014 SHALL have port expire, output, 1, single-cycle registered pulse on terminal count.
REQ-015 SHALL have port irq, output, 1, sticky expiry flag.
REQ-016 SHALL have port ovr, output, 1, sticky flag for expiry while irq is already set.

Function
REQ-017 SHALL apply command priority stop > start > pause > tick in every state; a lower-priority input in the same cycle is ignored.
REQ-018 SHALL, on start in IDLE, DONE or RUN with load_val != 0, latch load_val into the period register, latch periodic into the mode register, set cnt=load_val and enter RUN on the next edge; in RUN this is a restart.
REQ-019 SHALL ignore start with load_val==0 in IDLE, DONE or RUN: no state, cnt or register change.
REQ-020 SHALL, on start in PAUSE, resume RUN with cnt unchanged and no reload, whatever load_val is.
REQ-021 SHALL, in RUN on tick with cnt>1, set cnt=cnt-1.
REQ-022 SHALL, in RUN on tick with cnt==1, assert expire for exactly one cycle after that edge; in periodic mode reload cnt=period and stay in RUN; in one-shot mode set cnt=0 and enter DONE.
REQ-023 SHALL, in RUN on pause, enter PAUSE and hold cnt; ticks in PAUSE are ignored.
REQ-024 SHALL, on stop in any state, enter IDLE with cnt=0 and assert no expire; irq and ovr are unaffected.
REQ-025 SHALL ignore tick, pause and irq-free inputs in IDLE and DONE; cnt stays 0.
REQ-026 SHALL set irq on the edge that asserts expire and clear it on irq_clr; simultaneous set and clear leaves irq=1.
REQ-027 SHALL set ovr when expire is asserted while irq is already 1; irq_clr clears ovr; simultaneous set and clear leaves ovr=1.
REQ-028 SHALL drive busy combinationally from state; all other outputs are registered.
REQ-029 SHALL never let cnt wrap below 0 or exceed the latched period.
REQ-030 SHALL, with period 1 in periodic mode, expire on every tick.

Reset
REQ-031 SHALL, on rst_n low at any time including mid-count, immediately force state=IDLE, cnt=0, period=0, mode=0, expire=0, irq=0 and ovr=0.
REQ-032 SHALL resume normal operation on the first rising clk edge after rst_n deasserts; the first start is accepted on that edge.

Verification
REQ-033 One-shot: load_val=3, periodic=0, start, then 3 ticks -> cnt goes 3,2,1,0; expire pulses once, one cycle after the 3rd tick edge; state=DONE; irq=1; busy=0.
REQ-034 Periodic with overrun: load_val=2, periodic=1, 6 ticks, no irq_clr -> expire after ticks 2, 4 and 6; cnt reloads to 2 each time; ovr=1 after tick 4; irq_clr then gives irq=0 and ovr=0.
REQ-035 Pause/resume: load_val=5; 2 ticks; pause; 3 ticks; start; 3 ticks -> cnt holds 3 during pause; after resume counts 2,1,0; expire once; no reload from load_val.
REQ-036 Same-cycle commands: in RUN with cnt=1, assert tick+stop -> IDLE, cnt=0, no expire. Assert tick+start with load_val=7 -> cnt=7, no expire. Assert expire set together with irq_clr -> irq=1.
REQ-037 Zero load and reset: start with load_val=0 in IDLE -> state stays IDLE. Assert rst_n low mid-RUN at cnt=4 -> asynchronous clear of all outputs; first start after release is accepted.
